// File: rtl/data_bus_unit.sv
// Memory-mapped data bus: word RAM, GPIO register, cycle counter with compare/irq, sticky bus error.
// Reads are combinational (zero latency); writes commit on the rising edge of clk while WE is high.
module data_bus_unit #(
   parameter int RAM_WORDS = 256,
   parameter int GPIO_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              WE,
   input  logic [31:0]       address_to_mem,
   input  logic [31:0]       data_to_mem,
   output logic [31:0]       data_from_mem,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              irq,
   output logic              bus_err
);
   localparam int AW = $clog2(RAM_WORDS);

   localparam logic [2:0] SEL_GPIO  = 3'd0;
   localparam logic [2:0] SEL_COUNT = 3'd1;
   localparam logic [2:0] SEL_CMP   = 3'd2;
   localparam logic [2:0] SEL_CTRL  = 3'd3;
   localparam logic [2:0] SEL_ERR   = 3'd4;

   logic [31:0]       r_ram [RAM_WORDS];
   logic [GPIO_W-1:0] r_gpio;
   logic [31:0]       r_count;
   logic [31:0]       r_cmp;
   logic              r_en;
   logic              r_flag;
   logic              r_irq_en;
   logic              r_bus_err;

   logic              w_is_ram;
   logic              w_is_io;
   logic [2:0]        w_sel;
   logic [AW-1:0]     w_ram_idx;
   logic              w_wr_ram;
   logic              w_wr_gpio;
   logic              w_wr_count;
   logic              w_wr_cmp;
   logic              w_wr_ctrl;
   logic              w_wr_err;
   logic              w_match;
   logic              w_err_set;
   logic [31:0]       w_rdata;

   // Decode ignores address bits [1:0] so misaligned accesses still hit their word.
   assign w_is_ram  = (address_to_mem[31:AW+2] == '0);
   assign w_is_io   = (address_to_mem[31:5] == 27'h400_0000) && (address_to_mem[4:2] <= SEL_ERR);
   assign w_sel     = address_to_mem[4:2];
   assign w_ram_idx = address_to_mem[2 +: AW];

   assign w_wr_ram   = WE && w_is_ram;
   assign w_wr_gpio  = WE && w_is_io && (w_sel == SEL_GPIO);
   assign w_wr_count = WE && w_is_io && (w_sel == SEL_COUNT);
   assign w_wr_cmp   = WE && w_is_io && (w_sel == SEL_CMP);
   assign w_wr_ctrl  = WE && w_is_io && (w_sel == SEL_CTRL);
   assign w_wr_err   = WE && w_is_io && (w_sel == SEL_ERR);

   assign w_match   = r_en && (r_count == r_cmp);
   assign w_err_set = WE && ((address_to_mem[1:0] != 2'b00) || !(w_is_ram || w_is_io));

   always_ff @(posedge clk) begin
      if (w_wr_ram) begin
         r_ram[w_ram_idx] <= data_to_mem;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gpio    <= '0;
         r_count   <= '0;
         r_cmp     <= 32'hFFFF_FFFF;
         r_en      <= 1'b0;
         r_flag    <= 1'b0;
         r_irq_en  <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         if (w_wr_gpio) r_gpio <= data_to_mem[GPIO_W-1:0];
         r_count <= w_wr_count ? data_to_mem : r_count + 32'd1;
         if (w_wr_cmp) r_cmp <= data_to_mem;
         if (w_wr_ctrl) begin
            r_en     <= data_to_mem[0];
            r_irq_en <= data_to_mem[2];
         end
         // A match in the same cycle as a clear keeps the flag set.
         if (w_match) r_flag <= 1'b1;
         else if (w_wr_ctrl && data_to_mem[1]) r_flag <= 1'b0;
         if (w_wr_err) r_bus_err <= 1'b0;
         else if (w_err_set) r_bus_err <= 1'b1;
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_is_ram) begin
         w_rdata = r_ram[w_ram_idx];
      end else if (w_is_io) begin
         case (w_sel)
            SEL_GPIO:  w_rdata = 32'(r_gpio);
            SEL_COUNT: w_rdata = r_count;
            SEL_CMP:   w_rdata = r_cmp;
            SEL_CTRL:  w_rdata = {29'b0, r_irq_en, r_flag, r_en};
            SEL_ERR:   w_rdata = {31'b0, r_bus_err};
            default:   w_rdata = '0;
         endcase
      end
   end

   assign data_from_mem = w_rdata;
   assign gpio_out      = r_gpio;
   assign irq           = r_flag && r_irq_en;
   assign bus_err       = r_bus_err;
endmodule

// File: tb/tb_data_bus_unit.sv
// Bench for data_bus_unit: inputs change on the falling edge, outputs sampled 1ns later.
module tb_data_bus_unit;
   localparam int RAM_WORDS = 256;
   localparam int GPIO_W    = 8;

   localparam logic [31:0] A_GPIO  = 32'h8000_0000;
   localparam logic [31:0] A_COUNT = 32'h8000_0004;
   localparam logic [31:0] A_CMP   = 32'h8000_0008;
   localparam logic [31:0] A_CTRL  = 32'h8000_000C;
   localparam logic [31:0] A_ERR   = 32'h8000_0010;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              WE = 1'b0;
   logic [31:0]       address_to_mem = '0;
   logic [31:0]       data_to_mem = '0;
   logic [31:0]       data_from_mem;
   logic [GPIO_W-1:0] gpio_out;
   logic              irq;
   logic              bus_err;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   data_bus_unit #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
      .clk(clk), .reset(reset), .WE(WE), .address_to_mem(address_to_mem),
      .data_to_mem(data_to_mem), .data_from_mem(data_from_mem),
      .gpio_out(gpio_out), .irq(irq), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      WE = we; address_to_mem = a; data_to_mem = d;
      #1;
   endtask

   task automatic test_reset;
      #2 reset = 1'b1;
      #1;
      n_chk++; if ({gpio_out, irq, bus_err} !== '0) begin n_fail++; $display("FAIL reset_outputs: got gpio=%h irq=%b err=%b, want all 0", gpio_out, irq, bus_err); end
      address_to_mem = A_CMP; #1;
      n_chk++; if (data_from_mem !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp: got %h want ffffffff", data_from_mem); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; WE = 1'b0; address_to_mem = A_COUNT;
      #1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'(i));
         if (i > 0) drive(1'b0, A_COUNT, '0);
         e = exp_q.pop_front();
         n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL count_after_reset[%0d]: got %h want %h", i, data_from_mem, e); end
      end
   endtask

   task automatic test_ram;
      drive(1'b1, 32'h0000_0014, 32'h55AA_55AA);
      drive(1'b1, 32'h0000_0000, 32'h1111_1111);
      drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      exp_q.push_back(32'hDEAD_BEEF);
      drive(1'b0, 32'h0000_0010, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL ram_rt: got %h want %h", data_from_mem, e); end
      exp_q.push_back(32'h55AA_55AA);
      drive(1'b0, 32'h0000_0014, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL ram_neighbour: got %h want %h", data_from_mem, e); end
      n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL ram_no_err: got %b want 0", bus_err); end
      drive(1'b1, 32'(4 * RAM_WORDS), 32'h0000_0BAD);
      exp_q.push_back(32'h1111_1111);
      drive(1'b0, 32'h0000_0000, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL ram_oob_untouched: got %h want %h", data_from_mem, e); end
      n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL ram_oob_err: got %b want 1", bus_err); end
      drive(1'b1, A_ERR, '0);
   endtask

   task automatic test_gpio_err;
      drive(1'b1, A_GPIO, 32'h0000_01A5);
      exp_q.push_back(32'h0000_00A5);
      drive(1'b0, A_GPIO, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL gpio_read: got %h want %h", data_from_mem, e); end
      n_chk++; if (gpio_out !== 8'hA5) begin n_fail++; $display("FAIL gpio_out: got %h want a5", gpio_out); end
      n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared_before_gpio: got %b want 0", bus_err); end
      drive(1'b1, 32'h8000_0002, 32'h0000_003C);
      exp_q.push_back(32'h0000_0001);
      drive(1'b0, A_ERR, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL err_read: got %h want %h", data_from_mem, e); end
      n_chk++; if (gpio_out !== 8'h3C) begin n_fail++; $display("FAIL gpio_misaligned_write: got %h want 3c", gpio_out); end
      exp_q.push_back(32'h0000_0000);
      drive(1'b0, 32'h4000_0000, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL unmapped_read: got %h want %h", data_from_mem, e); end
      drive(1'b0, A_GPIO, '0);
      n_chk++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL read_keeps_err: got %b want 1", bus_err); end
      drive(1'b1, A_ERR, '0);
      drive(1'b0, A_GPIO, '0);
      n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", bus_err); end
      drive(1'b1, 32'h8000_0020, '0);
      drive(1'b1, 32'h8000_0011, '0);
      drive(1'b0, A_GPIO, '0);
      n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL misaligned_err_clear_wins: got %b want 0", bus_err); end
   endtask

   task automatic test_counter_wrap;
      logic [31:0] seq [3];
      seq[0] = 32'hFFFF_FFFE; seq[1] = 32'hFFFF_FFFF; seq[2] = 32'h0000_0000;
      drive(1'b1, A_COUNT, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(seq[i]);
         drive(1'b0, A_COUNT, '0);
         e = exp_q.pop_front();
         n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL count_wrap[%0d]: got %h want %h", i, data_from_mem, e); end
      end
   endtask

   task automatic test_timer;
      drive(1'b1, A_COUNT, 32'd10);
      drive(1'b1, A_CMP, 32'd20);
      drive(1'b1, A_CTRL, 32'h5);
      for (int i = 12; i <= 20; i++) begin
         exp_q.push_back(32'(i));
         drive(1'b0, A_COUNT, '0);
         e = exp_q.pop_front();
         n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL timer_count[%0d]: got %h want %h", i, data_from_mem, e); end
         n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early[%0d]: got %b want 0", i, irq); end
      end
      exp_q.push_back(32'h7);
      drive(1'b0, A_CTRL, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL ctrl_flag_set: got %h want %h", data_from_mem, e); end
      n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b want 1", irq); end
      drive(1'b1, A_CTRL, 32'h7);
      exp_q.push_back(32'h5);
      drive(1'b0, A_CTRL, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL ctrl_flag_clear: got %h want %h", data_from_mem, e); end
      n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
      drive(1'b1, A_CMP, 32'd50);
      drive(1'b1, A_COUNT, 32'd48);
      drive(1'b0, A_COUNT, '0);
      drive(1'b0, A_COUNT, '0);
      exp_q.push_back(32'd50);
      drive(1'b1, A_CTRL, 32'h7);
      drive(1'b0, A_COUNT, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e + 32'd1) begin n_fail++; $display("FAIL clear_vs_match_count: got %h want %h", data_from_mem, e + 32'd1); end
      exp_q.push_back(32'h7);
      drive(1'b0, A_CTRL, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL set_beats_clear: got %h want %h", data_from_mem, e); end
      n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_beats_clear: got %b want 1", irq); end
   endtask

   task automatic test_reset_mid;
      drive(1'b1, A_GPIO, 32'hFF);
      drive(1'b1, 32'h8000_0100, '0);
      drive(1'b1, A_GPIO, 32'h12);
      n_chk++; if ({gpio_out, irq, bus_err} !== {8'hFF, 1'b1, 1'b1}) begin n_fail++; $display("FAIL pre_reset_state: got gpio=%h irq=%b err=%b want ff 1 1", gpio_out, irq, bus_err); end
      #2 reset = 1'b1;
      #1;
      n_chk++; if ({gpio_out, irq, bus_err} !== '0) begin n_fail++; $display("FAIL async_reset: got gpio=%h irq=%b err=%b want all 0", gpio_out, irq, bus_err); end
      n_chk++; if (data_from_mem !== 32'h0) begin n_fail++; $display("FAIL async_reset_gpio_read: got %h want 0", data_from_mem); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; WE = 1'b0; address_to_mem = A_COUNT;
      #1;
      n_chk++; if (gpio_out !== 8'h00) begin n_fail++; $display("FAIL write_discarded_in_reset: got %h want 00", gpio_out); end
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(32'(i));
         if (i > 0) drive(1'b0, A_COUNT, '0);
         e = exp_q.pop_front();
         n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL count_restart[%0d]: got %h want %h", i, data_from_mem, e); end
      end
   endtask

   task automatic test_rdw;
      drive(1'b1, 32'h0000_000C, 32'hCAFE_0003);
      exp_q.push_back(32'hCAFE_0003);
      drive(1'b1, 32'h0000_000C, 32'h0000_1234);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL rdw_old: got %h want %h", data_from_mem, e); end
      exp_q.push_back(32'h0000_1234);
      drive(1'b0, 32'h0000_000C, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL rdw_new: got %h want %h", data_from_mem, e); end
      exp_q.push_back(32'h0);
      drive(1'b0, 32'h4000_0000, '0);
      e = exp_q.pop_front();
      n_chk++; if (data_from_mem !== e) begin n_fail++; $display("FAIL unmapped_read_zero: got %h want %h", data_from_mem, e); end
      drive(1'b0, 32'h0000_0000, '0);
      n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL unmapped_read_no_err: got %b want 0", bus_err); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_gpio_err();
      test_counter_wrap();
      test_timer();
      test_reset_mid();
      test_rdw();
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
